// File: rtl/write_seq_pkg.sv
// write_seq_pkg
//   Shared definitions for the write-sequence fetch path: write-engine
//   opcodes that the fetch stage needs to know about, default geometry
//   parameters, and the selector type for the mdat output mux.
//   No ports (package).

package write_seq_pkg;

  // Write-engine opcodes
  localparam logic [7:0] OP_STOP         = 8'h3F;
  localparam logic [7:0] OP_WAIT_TRKMARK = 8'h03;
  localparam logic [7:0] OP_STROBE       = 8'h02;
  localparam logic [7:0] OP_WGATE_BASE   = 8'h00;

  // Default geometry
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_RD_LAT = 2;
  localparam int DEF_DEPTH  = 4;

  // Source selected onto mdat
  typedef enum logic [1:0] {
    MDAT_STOP = 2'd0,
    MDAT_HEAD = 2'd1,
    MDAT_NEXT = 2'd2
  } mdat_sel_e;

endpackage

// File: rtl/write_seq_fifo.sv
// write_seq_fifo
//   Circular prefetch buffer of DEPTH bytes (DEPTH a power of two, >= 2).
//   Exposes the head entry and the entry after it so the consumer can see
//   one byte ahead.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   flush          : clear pointers and count (priority over push/pop)
//   push, wdata    : write one byte at the tail
//   pop            : retire the head entry (caller guarantees count >= 1)
//   head           : entry at the read pointer
//   head_next      : entry at read pointer + 1
//   count          : number of valid entries (clog2(DEPTH)+1 bits)

module write_seq_fifo
  import write_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [7:0]             head_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_inc;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_inc];

  // Buffer storage; contents need no reset because count qualifies every use.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_seq_fetch.sv
// write_seq_fetch
//   Prefetching instruction-fetch stage feeding the disc write engine.
//   Reads write-program bytes from SRAM into a small buffer and presents
//   them on mdat with one-byte look-ahead while maddr_inc is high.
//   Fetching begins with the first addr_load after reset.
// Optional feature macro: WRITE_SEQ_UNDERRUN_EN
//   defined   : sticky underrun flag, mdat forced to STOP while it is set
//   undefined : underrun tied low, no forcing logic
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   addr_load, addr_in   : load fetch pointer / head address and flush
//   start_in, start_out  : host START, gated until two bytes are buffered
//   maddr_inc            : retire-current-byte pulse from the engine
//   mdat                 : current (or look-ahead) instruction byte
//   sram_addr, sram_rd   : SRAM read request
//   sram_rdata           : SRAM read data, valid RD_LAT clocks after request
//   head_addr            : SRAM address of the byte currently on mdat
//   underrun             : sticky buffer-underrun flag

module write_seq_fetch
  import write_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              start_in,
  output logic              start_out,
  input  logic              maddr_inc,
  output logic [7:0]        mdat,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rd,
  input  logic [7:0]        sram_rdata,
  output logic [ADDR_W-1:0] head_addr,
  output logic              underrun
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              active;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [RD_LAT-1:0] inflight;
  logic [CW-1:0]     count;
  logic [7:0]        head;
  logic [7:0]        head_next;
  logic [31:0]       inflight_cnt;
  logic [31:0]       occupancy;
  logic              have_two;
  logic              issue;
  logic              capture;
  logic              retire;
  mdat_sel_e         mdat_sel;

  // Number of reads still travelling through the SRAM pipeline.
  always_comb begin
    inflight_cnt = 32'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + 32'(inflight[i]);
    end
  end

  // In-flight reads reserve their buffer slot so the buffer never overflows.
  assign occupancy = 32'(count) + inflight_cnt;
  assign have_two  = (count >= CW'(2));
  assign issue     = active && !addr_load && (occupancy < 32'(DEPTH));
  assign capture   = inflight[RD_LAT-1];
  assign retire    = maddr_inc && have_two && !addr_load;

  assign sram_rd   = issue;
  assign sram_addr = fetch_ptr;
  assign start_out = start_in && have_two;

  // Fetch pointer, in-flight tracker and head address; addr_load wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active    <= 1'b0;
      fetch_ptr <= '0;
      inflight  <= '0;
      head_addr <= '0;
    end else if (addr_load) begin
      active    <= 1'b1;
      fetch_ptr <= addr_in;
      inflight  <= '0;
      head_addr <= addr_in;
    end else begin
      if (issue) begin
        fetch_ptr <= fetch_ptr + ADDR_W'(1);
      end
      inflight <= (inflight << 1) | RD_LAT'(issue);
      if (retire) begin
        head_addr <= head_addr + ADDR_W'(1);
      end
    end
  end

  write_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (addr_load),
    .push      (capture),
    .wdata     (sram_rdata),
    .pop       (retire),
    .head      (head),
    .head_next (head_next),
    .count     (count)
  );

`ifdef WRITE_SEQ_UNDERRUN_EN
  logic underrun_flag;
  logic underrun_evt;

  // A retire request with fewer than two bytes buffered cannot be honoured.
  assign underrun_evt = maddr_inc && !have_two && !addr_load;

  // Sticky underrun flag, cleared only by a new program load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underrun_flag <= 1'b0;
    end else if (addr_load) begin
      underrun_flag <= 1'b0;
    end else if (underrun_evt) begin
      underrun_flag <= 1'b1;
    end else begin
      underrun_flag <= underrun_flag;
    end
  end

  assign underrun = underrun_flag;
`else
  assign underrun = 1'b0;
`endif

  // Select mdat source; an unhonourable retire leaves the stale head visible.
  always_comb begin
    mdat_sel = MDAT_STOP;
`ifdef WRITE_SEQ_UNDERRUN_EN
    if (underrun_flag) begin
      mdat_sel = MDAT_STOP;
    end else
`endif
    if (count == CW'(0)) begin
      mdat_sel = MDAT_STOP;
    end else if (maddr_inc && have_two) begin
      mdat_sel = MDAT_NEXT;
    end else begin
      mdat_sel = MDAT_HEAD;
    end
  end

  // mdat output mux.
  always_comb begin
    case (mdat_sel)
      MDAT_HEAD: mdat = head;
      MDAT_NEXT: mdat = head_next;
      default:   mdat = OP_STOP;
    endcase
  end

endmodule
